// File: rtl/ex_muldiv_unit_pkg.sv
// rtl/ex_muldiv_unit_pkg.sv - shared encodings for the RV32M multiply/divide unit
// Purpose: funct3 operation codes, M-extension funct7, FSM state type and
//          operand-signedness helpers shared by the EX-stage mul/div unit.
package ex_muldiv_unit_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  // funct7 that marks an OP-class instruction as M-extension (used by decode)
  localparam logic [6:0] MD_FUNCT7 = 7'b0000001;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic md_src1_signed(input logic [2:0] f);
    return (f == MD_MULH) || (f == MD_MULHSU) || (f == MD_DIV) || (f == MD_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM
  function automatic logic md_src2_signed(input logic [2:0] f);
    return (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// rtl/muldiv_iter_core.sv - one-bit-per-cycle shift-add / restoring-divide datapath
// Purpose: holds the product accumulator, partial remainder, operand B and the
//          iteration counter; advances one bit per i_step.
// Ports:   clk, rst      clock and synchronous active-high reset
//          i_load        capture magnitudes i_a/i_b, clear remainder and counter
//          i_step        perform one iteration (multiply or divide per i_div)
//          i_clear       clear the iteration counter (abort)
//          i_div         1 = restoring divide, 0 = shift-add multiply
//          o_acc         product (mul) / quotient in low half (div)
//          o_rem         remainder (div)
//          o_last        counter is on the final iteration
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_clear,
  input  logic              i_div,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic [2*XLEN-1:0] o_acc,
  output logic [XLEN-1:0]   o_rem,
  output logic              o_last
);

  localparam int CW = $clog2(XLEN);

  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_b;
  logic [CW-1:0]     r_count;

  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_rem_sh;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_sub;

  always_comb begin
    // multiply: add multiplicand into the upper half when the multiplier LSB is set,
    // keeping the carry so it shifts down into the accumulator
    w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    // divide: the dividend lives in r_acc low half and shifts out MSB-first
    w_rem_sh  = {r_rem, r_acc[XLEN-1]};
    w_ge      = (w_rem_sh >= {1'b0, r_b});
    // modulo-XLEN subtract is exact here because the true difference is below r_b
    w_rem_sub = w_rem_sh[XLEN-1:0] - r_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_rem   <= '0;
      r_b     <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_acc   <= {{XLEN{1'b0}}, i_a};
      r_rem   <= '0;
      r_b     <= i_b;
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_step) begin
      r_count <= r_count + 1'b1;
      if (i_div) begin
        r_rem <= w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0];
        r_acc <= {{XLEN{1'b0}}, r_acc[XLEN-2:0], w_ge};
      end else begin
        r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
      end
    end
  end

  assign o_acc  = r_acc;
  assign o_rem  = r_rem;
  assign o_last = (r_count == {CW{1'b1}});

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit for the EX stage
// Purpose: FSM, operand conditioning, fast-path detection, sign fix and output mux.
// Ports:   clk, rst       clock and synchronous active-high reset
//          MD_Start       valid M-extension instruction in EX
//          MD_Funct3      operation select
//          MD_Src1/Src2   forwarded rs1/rs2
//          MD_Kill        abort current operation
//          MD_Hold        downstream stall; freezes DONE
//          MD_Stall       stall request to PC/IF/ID/EX
//          MD_Valid       MD_Result valid this cycle
//          MD_Result      rd write value
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN = DATA_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MD_Start,
  input  logic [2:0]      MD_Funct3,
  input  logic [XLEN-1:0] MD_Src1,
  input  logic [XLEN-1:0] MD_Src2,
  input  logic            MD_Kill,
  input  logic            MD_Hold,
  output logic            MD_Stall,
  output logic            MD_Valid,
  output logic [XLEN-1:0] MD_Result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         r_state, w_next;
  logic [2:0]        r_funct3;
  logic              r_neg_res, r_neg_rem;
  logic              r_fast;
  logic [XLEN-1:0]   r_fast_val;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_src1_neg, w_src2_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic              w_div0, w_ovf, w_fast;
  logic [XLEN-1:0]   w_fast_val;
  logic [2*XLEN-1:0] w_acc, w_prod;
  logic [XLEN-1:0]   w_rem_mag, w_quot, w_rem, w_final;
  logic              w_last;

  // operand conditioning and fast-path detection on the accepted instruction
  always_comb begin
    w_src1_neg = md_src1_signed(MD_Funct3) & MD_Src1[XLEN-1];
    w_src2_neg = md_src2_signed(MD_Funct3) & MD_Src2[XLEN-1];
    w_a_mag    = w_src1_neg ? -MD_Src1 : MD_Src1;
    w_b_mag    = w_src2_neg ? -MD_Src2 : MD_Src2;
    w_div0     = MD_Funct3[2] & (MD_Src2 == '0);
    w_ovf      = ((MD_Funct3 == MD_DIV) || (MD_Funct3 == MD_REM)) &
                 (MD_Src1 == MIN_NEG) & (MD_Src2 == '1);
    w_fast     = w_div0 | w_ovf;
    // funct3[1] separates REM* from DIV*
    if (w_div0) w_fast_val = MD_Funct3[1] ? MD_Src1 : '1;
    else        w_fast_val = MD_Funct3[1] ? '0 : MIN_NEG;
  end

  assign w_accept = (r_state == MD_IDLE) & MD_Start & ~MD_Kill;
  assign MD_Stall = w_accept | (r_state == MD_BUSY);
  assign MD_Valid = (r_state == MD_DONE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      MD_IDLE: if (w_accept) w_next = w_fast ? MD_DONE : MD_BUSY;
      MD_BUSY: if (w_last)   w_next = MD_DONE;
      MD_DONE: if (!MD_Hold) w_next = MD_IDLE;
      default: w_next = MD_IDLE;
    endcase
    if (MD_Kill) w_next = MD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= MD_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_funct3   <= '0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_fast     <= 1'b0;
      r_fast_val <= '0;
    end else if (w_accept) begin
      r_funct3   <= MD_Funct3;
      r_neg_res  <= w_src1_neg ^ w_src2_neg;
      r_neg_rem  <= w_src1_neg;
      r_fast     <= w_fast;
      r_fast_val <= w_fast_val;
    end
  end

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_step  (r_state == MD_BUSY),
    .i_clear (MD_Kill),
    .i_div   (r_funct3[2]),
    .i_a     (w_a_mag),
    .i_b     (w_b_mag),
    .o_acc   (w_acc),
    .o_rem   (w_rem_mag),
    .o_last  (w_last)
  );

  // sign fix and result select; only meaningful while in DONE
  always_comb begin
    w_prod = r_neg_res ? -w_acc : w_acc;
    w_quot = r_neg_res ? -w_acc[XLEN-1:0] : w_acc[XLEN-1:0];
    w_rem  = r_neg_rem ? -w_rem_mag : w_rem_mag;
    case (r_funct3)
      MD_MUL:                      w_final = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             w_final = w_quot;
      default:                     w_final = w_rem;
    endcase
    if (r_fast) w_final = r_fast_val;
  end

  // keep the last delivered value visible once DONE is left
  always_ff @(posedge clk) begin
    if (rst)                     r_result <= '0;
    else if (r_state == MD_DONE) r_result <= w_final;
  end

  assign MD_Result = MD_Valid ? w_final : r_result;

endmodule
